// File: rtl/axi_lite_regfile.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_regfile
// Brief    : AXI4-Lite slave register file with byte strobes, decode errors,
//            per-register read-only mask and a flat register export.
//            Optional macro AXI_LITE_REGFILE_WR_PULSE_EN adds wr_pulse output.
// Revision : 1.0 - initial release
// ============================================================================
module axi_lite_regfile #(
    parameter int                      ADDR_WIDTH = 32,
    parameter int                      DATA_WIDTH = 32,
    parameter int                      NUM_REGS   = 32,
    parameter logic [NUM_REGS-1:0]     RO_MASK    = '0,
    parameter logic [DATA_WIDTH-1:0]   RESET_VAL  = '0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [ADDR_WIDTH-1:0]          awaddr,
    input  logic                           awvalid,
    output logic                           awready,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [DATA_WIDTH/8-1:0]        wstrb,
    input  logic                           wvalid,
    output logic                           wready,
    output logic [1:0]                     bresp,
    output logic                           bvalid,
    input  logic                           bready,
    input  logic [ADDR_WIDTH-1:0]          araddr,
    input  logic                           arvalid,
    output logic                           arready,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic [1:0]                     rresp,
    output logic                           rvalid,
    input  logic                           rready,
`ifdef AXI_LITE_REGFILE_WR_PULSE_EN
    output logic [NUM_REGS-1:0]            wr_pulse,
`endif
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q
);

    localparam int         c_strb_w = DATA_WIDTH / 8;
    localparam int         c_lsb    = $clog2(c_strb_w);
    localparam logic [1:0] c_okay   = 2'b00;
    localparam logic [1:0] c_slverr = 2'b10;

    logic                  r_aw_held;
    logic                  r_w_held;
    logic                  r_wr_go;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [c_strb_w-1:0]   r_wstrb;
    logic                  r_bvalid;
    logic [1:0]            r_bresp;
    logic                  r_rvalid;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_rresp;
    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_ar_hs;
    logic [ADDR_WIDTH-1:0] w_widx;
    logic [ADDR_WIDTH-1:0] w_ridx;
    logic                  w_wr_ok;
    logic                  w_rd_hit;
    logic [DATA_WIDTH-1:0] w_rd_data;

    assign awready = ~r_aw_held & ~r_bvalid;
    assign wready  = ~r_w_held & ~r_bvalid;
    assign arready = ~r_rvalid;

    assign w_aw_hs = awvalid & awready;
    assign w_w_hs  = wvalid & wready;
    assign w_ar_hs = arvalid & arready;

    assign w_widx  = r_awaddr >> c_lsb;
    assign w_ridx  = araddr >> c_lsb;

    assign bvalid  = r_bvalid;
    assign bresp   = r_bresp;
    assign rvalid  = r_rvalid;
    assign rdata   = r_rdata;
    assign rresp   = r_rresp;

    // Address decode: out-of-range indices match no register.
    always_comb begin
        w_wr_ok   = 1'b0;
        w_rd_hit  = 1'b0;
        w_rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_widx == ADDR_WIDTH'(i)) begin
                w_wr_ok = ~RO_MASK[i];
            end
            if (w_ridx == ADDR_WIDTH'(i)) begin
                w_rd_hit  = 1'b1;
                w_rd_data = r_regs[i];
            end
        end
    end

    // Write channel: capture AW/W independently, one idle cycle, then commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_wr_go   <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= c_okay;
        end else begin
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_awaddr  <= awaddr;
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_wdata  <= wdata;
                r_wstrb  <= wstrb;
            end
            r_wr_go <= r_aw_held & r_w_held & ~r_wr_go;
            if (r_wr_go) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= w_wr_ok ? c_okay : c_slverr;
            end else if (r_bvalid && bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= RESET_VAL;
            end
        end else if (r_wr_go && w_wr_ok) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_widx == ADDR_WIDTH'(i)) begin
                    for (int b = 0; b < c_strb_w; b++) begin
                        if (r_wstrb[b]) begin
                            r_regs[i][b*8 +: 8] <= r_wdata[b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    // Read channel: a register read in the same edge as a commit sees the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= c_okay;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_data;
            r_rresp  <= w_rd_hit ? c_okay : c_slverr;
        end else if (r_rvalid && rready) begin
            r_rvalid <= 1'b0;
        end
    end

`ifdef AXI_LITE_REGFILE_WR_PULSE_EN
    logic [NUM_REGS-1:0] r_wr_pulse;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_pulse <= '0;
        end else begin
            r_wr_pulse <= '0;
            if (r_wr_go && w_wr_ok) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (w_widx == ADDR_WIDTH'(i)) begin
                        r_wr_pulse[i] <= 1'b1;
                    end
                end
            end
        end
    end

    assign wr_pulse = r_wr_pulse;
`endif

    generate
        for (genvar g = 0; g < NUM_REGS; g++) begin : g_regq
            assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[g];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_lite_regfile
// Brief    : Randomized self-checking bench for axi_lite_regfile against an
//            array-based register model (8 x 32-bit, register 7 read-only).
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_lite_regfile;

    localparam int NREGS = 8;
    localparam logic [NREGS-1:0] RO = 8'h80;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [31:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [NREGS*32-1:0] reg_q;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int hs_cyc = 0;
    logic [31:0] mdl [NREGS];

    axi_lite_regfile #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(NREGS),
        .RO_MASK(RO), .RESET_VAL(32'h0)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .reg_q(reg_q)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] model_write(input logic [31:0] a, input logic [31:0] d,
                                               input logic [3:0] s);
        int idx = int'(a >> 2);
        if (idx >= NREGS || RO[idx]) return 2'b10;
        for (int b = 0; b < 4; b++)
            if (s[b]) mdl[idx][b*8 +: 8] = d[b*8 +: 8];
        return 2'b00;
    endfunction

    task automatic check_regs(input string tag);
        for (int i = 0; i < NREGS; i++)
            check(tag, {32'h0, reg_q[i*32 +: 32]}, {32'h0, mdl[i]});
    endtask

    task automatic send_aw(input logic [31:0] a);
        int n = 0;
        awaddr = a; awvalid = 1'b1;
        while (!awready && n < 50) begin @(negedge clk); n++; end
        if (!awready) check("aw_timeout", 64'(awready), 64'd1);
        @(posedge clk); @(negedge clk);
        awvalid = 1'b0; hs_cyc = cyc;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        wdata = d; wstrb = s; wvalid = 1'b1;
        while (!wready && n < 50) begin @(negedge clk); n++; end
        if (!wready) check("w_timeout", 64'(wready), 64'd1);
        @(posedge clk); @(negedge clk);
        wvalid = 1'b0; hs_cyc = cyc;
    endtask

    // mode 0: AW and W together, 1: AW first, 2: W first
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int mode, input int gap, input int bwait);
        logic [1:0] er;
        int n = 0;
        if (mode == 0) begin
            awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
            while (!(awready && wready) && n < 50) begin @(negedge clk); n++; end
            if (!(awready && wready)) check("aww_timeout", 64'(awready & wready), 64'd1);
            @(posedge clk); @(negedge clk);
            awvalid = 1'b0; wvalid = 1'b0; hs_cyc = cyc;
        end else if (mode == 1) begin
            send_aw(a);
            repeat (gap) @(negedge clk);
            send_w(d, s);
        end else begin
            send_w(d, s);
            repeat (gap) @(negedge clk);
            send_aw(a);
        end
        er = model_write(a, d, s);
        check("b_early0", 64'(bvalid), 64'd0);
        @(negedge clk);
        check("b_early1", 64'(bvalid), 64'd0);
        @(negedge clk);
        check("b_latency", 64'(bvalid), 64'd1);
        check("bresp", 64'(bresp), 64'(er));
        check_regs("reg_q_wr");
        for (int k = 0; k < bwait; k++) begin
            @(negedge clk);
            check("b_hold", {62'h0, bvalid, awready | wready}, {62'h0, 1'b1, 1'b0});
            check("bresp_hold", 64'(bresp), 64'(er));
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        check("b_release", {62'h0, bvalid, awready & wready}, {62'h0, 1'b0, 1'b1});
    endtask

    task automatic do_read(input logic [31:0] a, input int rwait);
        int idx = int'(a >> 2);
        logic [31:0] ed = (idx < NREGS) ? mdl[idx] : 32'h0;
        logic [1:0]  er = (idx < NREGS) ? 2'b00 : 2'b10;
        check("arready_idle", 64'(arready), 64'd1);
        araddr = a; arvalid = 1'b1;
        @(posedge clk); @(negedge clk);
        arvalid = 1'b0;
        check("r_latency", 64'(rvalid), 64'd1);
        check("rdata", 64'(rdata), 64'(ed));
        check("rresp", 64'(rresp), 64'(er));
        for (int k = 0; k < rwait; k++) begin
            @(negedge clk);
            check("r_hold", {30'h0, rvalid, arready, rresp, rdata}, {30'h0, 1'b1, 1'b0, er, ed});
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        check("r_release", {62'h0, rvalid, arready}, {62'h0, 1'b0, 1'b1});
    endtask

    initial begin
        logic [31:0] a, d, old;
        for (int i = 0; i < NREGS; i++) mdl[i] = 32'h0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", {61'h0, awready, wready, arready}, {61'h0, 3'b111});
        check("rst_valid", {62'h0, bvalid, rvalid}, 64'd0);
        check("rst_resp", {28'h0, bresp, rresp, rdata}, 64'd0);
        check_regs("rst_regs");
        rst_n = 1'b1;
        @(negedge clk);

        do_read(32'h04, 0);
        do_write(32'h08, 32'hDEADBEEF, 4'hF, 1, 3, 0);
        do_read(32'h08, 0);
        do_write(32'h08, 32'h11223344, 4'b0101, 2, 2, 1);
        check("merge", 64'(reg_q[2*32 +: 32]), 64'h0000_0000_DE22_BE44);
        do_write(32'h1C, 32'hCAFEF00D, 4'hF, 0, 0, 0);
        do_write(32'h40, 32'h12345678, 4'hF, 0, 0, 0);
        do_read(32'h40, 0);
        do_read(32'h1C, 0);
        do_write(32'h0C, 32'hA5A5A5A5, 4'h0, 0, 0, 5);
        do_read(32'h08, 5);

        // Read handshaking on the commit edge of a write to the same register
        old = mdl[3];
        d = $urandom;
        awaddr = 32'h0C; wdata = d; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        @(posedge clk); @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        araddr = 32'h0C; arvalid = 1'b1;
        @(posedge clk); @(negedge clk);
        arvalid = 1'b0;
        check("coll_rvalid", {62'h0, rvalid, bvalid}, {62'h0, 2'b11});
        check("coll_old", 64'(rdata), 64'(old));
        void'(model_write(32'h0C, d, 4'hF));
        check("coll_new", 64'(reg_q[3*32 +: 32]), 64'(d));
        bready = 1'b1; rready = 1'b1;
        @(negedge clk);
        bready = 1'b0; rready = 1'b0;

        for (int it = 0; it < 60; it++) begin
            a = ($urandom_range(0, 11) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1)
                do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2),
                         $urandom_range(0, 3), $urandom_range(0, 3));
            else
                do_read(a, $urandom_range(0, 3));
        end

        // Reset with AW captured and W still outstanding
        send_aw(32'h10);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_ready", {61'h0, awready, wready, arready}, {61'h0, 3'b111});
        check("mid_rst_valid", {62'h0, bvalid, rvalid}, 64'd0);
        for (int i = 0; i < NREGS; i++) mdl[i] = 32'h0;
        check_regs("mid_rst_regs");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("post_rst_nob", 64'(bvalid), 64'd0);
        end
        do_read(32'h10, 0);
        do_write(32'h10, 32'h0BADF00D, 4'hF, 0, 0, 0);
        do_read(32'h10, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
